// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32/RV64 opcode, jump and ALU encodings plus immediate extraction helpers
package rv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] JUMP_NONE   = 2'd0;
  localparam logic [1:0] JUMP_JAL    = 2'd1;
  localparam logic [1:0] JUMP_JALR   = 2'd2;
  localparam logic [1:0] JUMP_BRANCH = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  // Helpers sign-extend to the widest XLEN; callers size-cast down to their own XLEN.
  typedef logic [63:0] imm_t;

  function automatic imm_t imm_i(input logic [31:0] instr);
    return {{52{instr[31]}}, instr[31:20]};
  endfunction

  function automatic imm_t imm_s(input logic [31:0] instr);
    return {{52{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic imm_t imm_b(input logic [31:0] instr);
    return {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic imm_t imm_j(input logic [31:0] instr);
    return {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic imm_t imm_u(input logic [31:0] instr);
    return {{32{instr[31]}}, instr[31:12], 12'b0};
  endfunction

  function automatic imm_t imm_shamt(input logic [31:0] instr, input logic xlen64);
    return xlen64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake interfaces of the decode stage
interface fetch_if #(parameter int XLEN = 32);
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;

  modport master (output i_valid, i_instr, i_pc, input o_ready);
  modport slave  (input i_valid, i_instr, i_pc, output o_ready);
endinterface

interface issue_if #(parameter int XLEN = 32);
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_pc;
  logic [4:0]      o_rd;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic            o_en_imm;
  logic [XLEN-1:0] o_imm;
  logic            o_en_jump;
  logic [XLEN-1:0] o_jump_addr;
  logic [3:0]      o_alu_op;
  logic [1:0]      o_jump;
  logic            o_load;
  logic            o_store;
  logic            o_mul;
  logic            o_illegal_instruction;

  modport master (output o_valid, o_pc, o_rd, o_rs1, o_rs2, o_en_imm, o_imm, o_en_jump,
                  o_jump_addr, o_alu_op, o_jump, o_load, o_store, o_mul,
                  o_illegal_instruction, input i_ready);
  modport slave  (input o_valid, o_pc, o_rd, o_rs1, o_rs2, o_en_imm, o_imm, o_en_jump,
                  o_jump_addr, o_alu_op, o_jump, o_load, o_store, o_mul,
                  o_illegal_instruction, output i_ready);
endinterface

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - purely combinational instr+pc to decoded bundle function
module decode_comb
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EN_M = 0
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic            en_imm_o,
  output logic [XLEN-1:0] imm_o,
  output logic            en_jump_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic [3:0]      alu_op_o,
  output logic [1:0]      jump_o,
  output logic            load_o,
  output logic            store_o,
  output logic            mul_o,
  output logic            illegal_o
);

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] i_x, s_x, b_x, j_x, u_x, sh_x;
  logic            is_mul;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign i_x    = XLEN'(imm_i(instr_i));
  assign s_x    = XLEN'(imm_s(instr_i));
  assign b_x    = XLEN'(imm_b(instr_i));
  assign j_x    = XLEN'(imm_j(instr_i));
  assign u_x    = XLEN'(imm_u(instr_i));
  assign sh_x   = XLEN'(imm_shamt(instr_i, XLEN == 64));
  assign is_mul = (EN_M != 0) && (funct7 == F7_MULDIV);

  always_comb begin
    rd_o        = 5'd0;
    rs1_o       = 5'd0;
    rs2_o       = 5'd0;
    en_imm_o    = 1'b0;
    imm_o       = '0;
    en_jump_o   = 1'b0;
    jump_addr_o = pc_i + b_x;
    alu_op_o    = ALU_ADD;
    jump_o      = JUMP_NONE;
    load_o      = 1'b0;
    store_o     = 1'b0;
    mul_o       = 1'b0;
    illegal_o   = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        rd_o      = instr_i[11:7];
        rs1_o     = instr_i[19:15];
        rs2_o     = instr_i[24:20];
        mul_o     = is_mul;
        alu_op_o  = is_mul ? {1'b0, funct3} : {instr_i[30], funct3};
        illegal_o = !((funct7 == F7_BASE) || (funct7 == F7_ALT) || is_mul);
      end
      OPC_OP_IMM: begin
        rd_o     = instr_i[11:7];
        rs1_o    = instr_i[19:15];
        en_imm_o = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_o    = sh_x;
          alu_op_o = {instr_i[30], funct3};
        end else begin
          imm_o    = i_x;
          alu_op_o = {1'b0, funct3};
        end
      end
      OPC_LUI: begin
        rd_o     = instr_i[11:7];
        en_imm_o = 1'b1;
        imm_o    = u_x;
      end
      OPC_AUIPC: begin
        rd_o        = instr_i[11:7];
        en_imm_o    = 1'b1;
        imm_o       = u_x;
        en_jump_o   = 1'b1;
        jump_addr_o = pc_i;
      end
      OPC_JAL: begin
        rd_o        = instr_i[11:7];
        en_imm_o    = 1'b1;
        imm_o       = pc_i + XLEN'(4);
        en_jump_o   = 1'b1;
        jump_addr_o = pc_i + j_x;
        jump_o      = JUMP_JAL;
      end
      OPC_JALR: begin
        rd_o        = instr_i[11:7];
        rs1_o       = instr_i[19:15];
        en_imm_o    = 1'b1;
        imm_o       = i_x;
        en_jump_o   = 1'b1;
        jump_addr_o = pc_i;
        jump_o      = JUMP_JALR;
      end
      OPC_BRANCH: begin
        rs1_o     = instr_i[19:15];
        rs2_o     = instr_i[24:20];
        en_jump_o = 1'b1;
        jump_o    = JUMP_BRANCH;
        // Negated funct3 maps BEQ..BGEU onto the ALU compare op slots.
        alu_op_o  = {1'b1, 3'(3'd0 - funct3)};
      end
      OPC_LOAD: begin
        rd_o     = instr_i[11:7];
        rs1_o    = instr_i[19:15];
        en_imm_o = 1'b1;
        imm_o    = i_x;
        load_o   = 1'b1;
      end
      OPC_STORE: begin
        rs1_o    = instr_i[19:15];
        rs2_o    = instr_i[24:20];
        en_imm_o = 1'b1;
        imm_o    = s_x;
        store_o  = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - input queue plus registered decode output with valid/ready and flush
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int EN_M  = 0
) (
  input logic     i_clk,
  input logic     i_rst_n,
  input logic     i_flush,
  fetch_if.slave  fetch,
  issue_if.master issue
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = XLEN + 32;
  localparam int BW = 3 * XLEN + 27;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [BW-1:0] bundle_q, bundle_d, dec_bundle;

  logic          full, empty, in_xfer, out_load, push, pop;
  logic [EW-1:0] src;

  logic [4:0]      d_rd, d_rs1, d_rs2;
  logic [XLEN-1:0] d_imm, d_jaddr;
  logic [3:0]      d_alu;
  logic [1:0]      d_jump;
  logic            d_en_imm, d_en_jump, d_load, d_store, d_mul, d_ill;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign fetch.o_ready = i_rst_n && !full;
  assign in_xfer       = fetch.i_valid && fetch.o_ready;
  assign out_load      = !valid_q || issue.i_ready;
  assign pop           = out_load && !empty;
  // With an empty queue a free output register takes the incoming word directly.
  assign push          = in_xfer && !(out_load && empty);
  assign src           = empty ? {fetch.i_pc, fetch.i_instr} : mem_q[rd_ptr_q];

  decode_comb #(.XLEN(XLEN), .EN_M(EN_M)) u_decode (
    .instr_i     (src[31:0]),
    .pc_i        (src[EW-1:32]),
    .rd_o        (d_rd),
    .rs1_o       (d_rs1),
    .rs2_o       (d_rs2),
    .en_imm_o    (d_en_imm),
    .imm_o       (d_imm),
    .en_jump_o   (d_en_jump),
    .jump_addr_o (d_jaddr),
    .alu_op_o    (d_alu),
    .jump_o      (d_jump),
    .load_o      (d_load),
    .store_o     (d_store),
    .mul_o       (d_mul),
    .illegal_o   (d_ill)
  );

  assign dec_bundle = {src[EW-1:32], d_rd, d_rs1, d_rs2, d_en_imm, d_imm, d_en_jump, d_jaddr,
                       d_alu, d_jump, d_load, d_store, d_mul, d_ill};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
      if (out_load) begin
        valid_d = !empty || in_xfer;
        if (!empty || in_xfer) bundle_d = dec_bundle;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && push) mem_q[wr_ptr_q] <= {fetch.i_pc, fetch.i_instr};
  end

  assign issue.o_valid = valid_q;
  assign {issue.o_pc, issue.o_rd, issue.o_rs1, issue.o_rs2, issue.o_en_imm, issue.o_imm,
          issue.o_en_jump, issue.o_jump_addr, issue.o_alu_op, issue.o_jump, issue.o_load,
          issue.o_store, issue.o_mul, issue.o_illegal_instruction} = bundle_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage, EN_M=1 and EN_M=0 instances in lockstep
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic        en_imm;
    logic [31:0] imm;
    logic        en_jump;
    logic [31:0] jaddr;
    logic [3:0]  alu;
    logic [1:0]  jump;
    logic        load, store, mul, ill;
  } bun_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fx_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        v = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  bit          last_acc;
  int          n_cmp = 0;
  int          n_bad = 0;
  fx_t         sb[$];

  always #5 clk = ~clk;

  fetch_if #(XLEN) fa ();
  fetch_if #(XLEN) fb ();
  issue_if #(XLEN) ia ();
  issue_if #(XLEN) ib ();

  assign fa.i_valid = v;
  assign fa.i_instr = instr;
  assign fa.i_pc    = pc;
  assign fb.i_valid = v;
  assign fb.i_instr = instr;
  assign fb.i_pc    = pc;
  assign ia.i_ready = rdy;
  assign ib.i_ready = rdy;

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .EN_M(1)) dut_m (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .fetch(fa), .issue(ia));
  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .EN_M(0)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .fetch(fb), .issue(ib));

  // Reference decode from the ISA field layout, immediates built arithmetically.
  function automatic bun_t model(input logic [31:0] ins, input logic [31:0] p, input bit en_m);
    bun_t b;
    int   op, f3, f7, immI, immS, immB, immJ;
    bit   ismul;
    b    = '0;
    b.pc = p;
    op   = int'(ins[6:0]);
    f3   = int'(ins[14:12]);
    f7   = int'(ins[31:25]);
    immI = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
    immS = int'({ins[30:25], ins[11:7]}) - (ins[31] ? 2048 : 0);
    immB = 2 * int'({ins[30:25], ins[11:8]}) + (ins[7] ? 2048 : 0) - (ins[31] ? 4096 : 0);
    immJ = 2 * int'(ins[30:21]) + (ins[20] ? 2048 : 0) + 4096 * int'(ins[19:12])
         - (ins[31] ? (1 << 20) : 0);
    b.jaddr = p + 32'(immB);
    case (op)
      'h33: begin
        b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.rs2 = ins[24:20];
        ismul = en_m && (f7 == 1);
        b.mul = ismul;
        b.alu = ismul ? 4'(f3) : 4'(f3 + (ins[30] ? 8 : 0));
        b.ill = !(f7 == 0 || f7 == 'h20 || ismul);
      end
      'h13: begin
        b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.en_imm = 1'b1;
        if (f3 == 1 || f3 == 5) begin
          b.imm = 32'(ins[24:20]);
          b.alu = 4'(f3 + (ins[30] ? 8 : 0));
        end else begin
          b.imm = 32'(immI);
          b.alu = 4'(f3);
        end
      end
      'h37: begin b.rd = ins[11:7]; b.en_imm = 1'b1; b.imm = {ins[31:12], 12'h000}; end
      'h17: begin
        b.rd = ins[11:7]; b.en_imm = 1'b1; b.imm = {ins[31:12], 12'h000};
        b.en_jump = 1'b1; b.jaddr = p;
      end
      'h6F: begin
        b.rd = ins[11:7]; b.en_imm = 1'b1; b.imm = p + 32'd4;
        b.en_jump = 1'b1; b.jaddr = p + 32'(immJ); b.jump = 2'd1;
      end
      'h67: begin
        b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.en_imm = 1'b1; b.imm = 32'(immI);
        b.en_jump = 1'b1; b.jaddr = p; b.jump = 2'd2;
      end
      'h63: begin
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.en_jump = 1'b1; b.jump = 2'd3;
        b.alu = 4'(8 + ((8 - f3) % 8));
      end
      'h03: begin
        b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.en_imm = 1'b1; b.imm = 32'(immI); b.load = 1'b1;
      end
      'h23: begin
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.en_imm = 1'b1; b.imm = 32'(immS);
        b.store = 1'b1;
      end
      'h0F, 'h73: ;
      default: b.ill = 1'b1;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [6:0]  f7s [4];
    logic [31:0] r;
    int          sel;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    r   = $urandom;
    sel = $urandom_range(0, 13);
    if (sel < 11) r[6:0] = ops[sel];
    else if (sel > 11) r[6:0] = 7'h33;
    if (r[6:0] == 7'h33 && $urandom_range(0, 4) != 0) r[31:25] = f7s[$urandom_range(0, 3)];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; the scoreboard records what the fetch side handed over.
  task automatic cyc(input bit vv, input logic [31:0] ii, input logic [31:0] pp,
                     input bit rr, input bit ff, input bit rn);
    @(negedge clk);
    v = vv; instr = ii; pc = pp; rdy = rr; flush = ff; rst_n = rn;
    #4;
    last_acc = vv && fa.o_ready;
    if (!rn || ff) sb.delete();
    else if (last_acc) sb.push_back('{pp, ii});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin : monitor
    fx_t  e;
    bun_t act_a, act_b, exp_a, exp_b;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && !flush && ia.o_valid && rdy) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_bundle pc=%0h act_valid=1 exp_valid=0", ia.o_pc);
        end else begin
          e = sb.pop_front();
          exp_a = model(e.instr, e.pc, 1'b1);
          exp_b = model(e.instr, e.pc, 1'b0);
          act_a = '{ia.o_pc, ia.o_rd, ia.o_rs1, ia.o_rs2, ia.o_en_imm, ia.o_imm, ia.o_en_jump,
                    ia.o_jump_addr, ia.o_alu_op, ia.o_jump, ia.o_load, ia.o_store, ia.o_mul,
                    ia.o_illegal_instruction};
          act_b = '{ib.o_pc, ib.o_rd, ib.o_rs1, ib.o_rs2, ib.o_en_imm, ib.o_imm, ib.o_en_jump,
                    ib.o_jump_addr, ib.o_alu_op, ib.o_jump, ib.o_load, ib.o_store, ib.o_mul,
                    ib.o_illegal_instruction};
          n_cmp += 2;
          if (act_a !== exp_a) begin
            n_bad++;
            $display("FAIL bundle_m instr=%h act=%h exp=%h", e.instr, act_a, exp_a);
          end
          if (act_b !== exp_b || ib.o_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bundle_n instr=%h act=%h exp=%h", e.instr, act_b, exp_b);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_o_valid", ia.o_valid, 0);
    chk("rst_o_ready", fa.o_ready, 0);
    chk("rst_o_pc", ia.o_pc, 0);
    chk("rst_o_illegal", ia.o_illegal_instruction, 0);
    chk("rst_o_imm", ia.o_imm, 0);
    idle(1);
    chk("post_rst_o_ready", fa.o_ready, 1);

    cyc(1'b1, 32'hFFF10093, 32'h0, 1'b1, 1'b0, 1'b1);
    idle(1);
    chk("addi_valid", ia.o_valid, 1);
    chk("addi_rd", ia.o_rd, 1);
    chk("addi_rs1", ia.o_rs1, 2);
    chk("addi_rs2", ia.o_rs2, 0);
    chk("addi_en_imm", ia.o_en_imm, 1);
    chk("addi_imm", ia.o_imm, 32'hFFFFFFFF);
    chk("addi_alu", ia.o_alu_op, 0);

    cyc(1'b1, 32'h008000EF, 32'h100, 1'b1, 1'b0, 1'b1);
    idle(1);
    chk("jal_imm", ia.o_imm, 32'h104);
    chk("jal_jaddr", ia.o_jump_addr, 32'h108);
    chk("jal_jump", ia.o_jump, 1);
    chk("jal_en_jump", ia.o_en_jump, 1);
    chk("jal_rd", ia.o_rd, 1);

    cyc(1'b1, 32'hFE208EE3, 32'h200, 1'b1, 1'b0, 1'b1);
    idle(1);
    chk("beq_jaddr", ia.o_jump_addr, 32'h1FC);
    chk("beq_alu", ia.o_alu_op, 4'b1000);
    chk("beq_jump", ia.o_jump, 3);
    chk("beq_rd", ia.o_rd, 0);
    chk("beq_rs1", ia.o_rs1, 1);
    chk("beq_rs2", ia.o_rs2, 2);

    cyc(1'b1, 32'h402081B3, 32'h204, 1'b1, 1'b0, 1'b1);
    idle(1);
    chk("sub_alu", ia.o_alu_op, 4'b1000);

    cyc(1'b1, 32'h022081B3, 32'h208, 1'b1, 1'b0, 1'b1);
    idle(1);
    chk("mul_m_mul", ia.o_mul, 1);
    chk("mul_m_illegal", ia.o_illegal_instruction, 0);
    chk("mul_n_illegal", ib.o_illegal_instruction, 1);
    chk("mul_n_mul", ib.o_mul, 0);

    cyc(1'b1, 32'h0000007F, 32'h20C, 1'b1, 1'b0, 1'b1);
    idle(1);
    chk("opc7f_illegal", ia.o_illegal_instruction, 1);
    idle(1);

    acc = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, rand_instr(), 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
      acc += int'(last_acc);
    end
    chk("fill_accepted", 64'(acc), 3);
    chk("fill_o_ready", fa.o_ready, 0);
    idle(6);
    chk("fill_drained", 64'(sb.size()), 0);

    for (int i = 0; i < 3; i++) cyc(1'b1, rand_instr(), 32'h2000 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h00500093, 32'h3000, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("flush_o_valid", ia.o_valid, 0);
    chk("flush_o_ready", fa.o_ready, 1);
    idle(4);

    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFFFFFC,
          $urandom_range(0, 9) < 7, $urandom_range(0, 40) == 0, 1'b1);
    idle(8);
    chk("random_drained", 64'(sb.size()), 0);

    for (int i = 0; i < 3; i++) cyc(1'b1, rand_instr(), 32'h4000 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, rand_instr(), 32'h5000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("midrst_o_valid", ia.o_valid, 0);
    chk("midrst_o_ready", fa.o_ready, 0);
    chk("midrst_o_pc", ia.o_pc, 0);
    chk("midrst_o_imm", ia.o_imm, 0);
    chk("midrst_o_rd", ia.o_rd, 0);
    chk("midrst_o_alu", ia.o_alu_op, 0);
    idle(1);
    chk("midrst_release_ready", fa.o_ready, 1);
    idle(4);
    chk("final_drained", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
